cmd_ram_writer: RTL and testbench



---
 rtl/cmd_ram_writer.sv | 128 ++++++++++++
 tb/tb_cmd_ram_writer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_ram_writer.sv
// Buffers CMD loader byte writes in a small FIFO and drains them into the shared RAM
// port on arbiter-free cycles, holding the CPU off the bus and issuing the entry jump afterwards.
module cmd_ram_writer #(
    parameter int ADDR         = 16,
    parameter int DATA         = 8,
    parameter int FIFO_AW      = 3,
    parameter int AFULL_MARGIN = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            loader_download,
    input  logic            loader_wr,
    input  logic [ADDR-1:0] loader_addr,
    input  logic [DATA-1:0] loader_data,
    input  logic            execute_enable,
    input  logic [ADDR-1:0] execute_addr,
    input  logic            mem_slot,
    output logic            ram_we,
    output logic [ADDR-1:0] ram_addr,
    output logic [DATA-1:0] ram_din,
    output logic            ioctl_wait,
    output logic            cpu_hold,
    output logic            jump_req,
    output logic [ADDR-1:0] jump_addr,
    input  logic            jump_ack,
    output logic            overflow,
    output logic [15:0]     write_count
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int PW    = FIFO_AW + 1;
    localparam logic [PW-1:0] AFULL_LVL = PW'(DEPTH - AFULL_MARGIN);

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, JUMP, RELEASE} state_t;

    state_t state, next_state;

    logic [ADDR+DATA-1:0] fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, count, count_nxt;
    logic download_q, exec_pending;
    logic full, empty, accept_wr, push, pop, load_start;
    logic cpu_hold_nxt, jump_req_nxt;

    assign count      = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign accept_wr  = loader_wr && ((state == LOAD) || (state == DRAIN));
    assign pop        = mem_slot && !empty;
    // A full FIFO can still take a byte when the head leaves in the same cycle.
    assign push       = accept_wr && (!full || pop);
    assign count_nxt  = count + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
    assign load_start = (state == IDLE) && loader_download && !download_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load_start) next_state = LOAD;
            LOAD:    if (!loader_download) next_state = DRAIN;
            // Wait for the last RAM strobe to retire and no late byte to arrive.
            DRAIN:   if (empty && !ram_we && !push) next_state = exec_pending ? JUMP : RELEASE;
            JUMP:    if (jump_ack) next_state = RELEASE;
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cpu_hold_nxt = (next_state != IDLE);
        jump_req_nxt = (next_state == JUMP);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            download_q   <= 1'b0;
            cpu_hold     <= 1'b0;
            jump_req     <= 1'b0;
            jump_addr    <= '0;
            exec_pending <= 1'b0;
            overflow     <= 1'b0;
            write_count  <= '0;
            ioctl_wait   <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_din      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            download_q <= loader_download;
            cpu_hold   <= cpu_hold_nxt;
            jump_req   <= jump_req_nxt;
            ioctl_wait <= (count_nxt >= AFULL_LVL);
            ram_we     <= pop;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr              <= rd_ptr + 1'b1;
                {ram_addr, ram_din} <= fifo_mem[rd_ptr[FIFO_AW-1:0]];
            end

            if (load_start) begin
                write_count  <= '0;
                overflow     <= 1'b0;
                exec_pending <= 1'b0;
            end else begin
                if (pop && (write_count != 16'hFFFF)) write_count <= write_count + 16'd1;
                if (accept_wr && full && !pop) overflow <= 1'b1;
                if ((state == LOAD) && execute_enable) begin
                    exec_pending <= 1'b1;
                    jump_addr    <= execute_addr;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= {loader_addr, loader_data};
    end

endmodule

// File: tb/tb_cmd_ram_writer.sv
// Directed bench for cmd_ram_writer: single byte, back-pressure, full FIFO, entry jump,
// mid-load reset and a long pointer-wrapping load.
module tb_cmd_ram_writer;

    logic        clock = 1'b0;
    logic        reset;
    logic        loader_download, loader_wr, execute_enable, mem_slot, jump_ack;
    logic [15:0] loader_addr, execute_addr;
    logic [7:0]  loader_data;
    logic        ram_we, ioctl_wait, cpu_hold, jump_req, overflow;
    logic [15:0] ram_addr, jump_addr, write_count;
    logic [7:0]  ram_din;

    int n_cmp = 0;
    int n_err = 0;
    logic saw_jump;

    logic [15:0] mon_addr[$];
    logic [7:0]  mon_data[$];

    cmd_ram_writer dut (
        .clock(clock), .reset(reset),
        .loader_download(loader_download), .loader_wr(loader_wr),
        .loader_addr(loader_addr), .loader_data(loader_data),
        .execute_enable(execute_enable), .execute_addr(execute_addr),
        .mem_slot(mem_slot), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ioctl_wait(ioctl_wait), .cpu_hold(cpu_hold), .jump_req(jump_req),
        .jump_addr(jump_addr), .jump_ack(jump_ack), .overflow(overflow),
        .write_count(write_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (ram_we) begin
            mon_addr.push_back(ram_addr);
            mon_data.push_back(ram_din);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (jump_req) saw_jump = 1'b1;
    endtask

    task automatic push_byte(input logic [15:0] a, input logic [7:0] d);
        loader_wr   = 1'b1;
        loader_addr = a;
        loader_data = d;
        step();
        loader_wr = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (cpu_hold && n < max_cyc) begin
            step();
            n++;
        end
        chk("release_timeout", cpu_hold, 0);
    endtask

    initial begin
        int pushed;
        int n;
        int bad;
        reset = 1'b1;
        loader_download = 0; loader_wr = 0; execute_enable = 0; mem_slot = 0; jump_ack = 0;
        loader_addr = 0; loader_data = 0; execute_addr = 0;
        saw_jump = 0;
        step(); step();
        chk("rst_ram_we", ram_we, 0);
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_ioctl_wait", ioctl_wait, 0);
        chk("rst_jump_req", jump_req, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_write_count", write_count, 0);
        reset = 1'b0;
        step();

        // Single byte, mem_slot tied high
        mem_slot = 1; loader_download = 1;
        step();
        chk("t1_hold_on", cpu_hold, 1);
        push_byte(16'h5200, 8'h3E);
        chk("t1_no_we_at_push", ram_we, 0);
        step();
        chk("t1_we", ram_we, 1);
        chk("t1_addr", ram_addr, 16'h5200);
        chk("t1_din", ram_din, 8'h3E);
        loader_download = 0;
        step();
        chk("t1_we_one_cycle", ram_we, 0);
        wait_idle(20);
        chk("t1_nwr", mon_addr.size(), 1);
        chk("t1_count", write_count, 1);
        chk("t1_no_jump", saw_jump, 0);

        // Back-pressure and overflow
        mon_addr.delete(); mon_data.delete();
        mem_slot = 0; loader_download = 1;
        step();
        for (int i = 0; i < 9; i++) begin
            push_byte(16'h1000 + 16'(i), 8'hA0 + 8'(i));
            if (i == 4) chk("t2_wait_after5", ioctl_wait, 0);
            if (i == 5) chk("t2_wait_after6", ioctl_wait, 1);
            if (i == 7) chk("t2_no_ovf_at8", overflow, 0);
        end
        chk("t2_ovf", overflow, 1);
        mem_slot = 1; loader_download = 0;
        wait_idle(50);
        chk("t2_nwr", mon_addr.size(), 8);
        if (mon_addr.size() == 8)
            for (int i = 0; i < 8; i++) begin
                chk("t2_order_addr", mon_addr[i], 16'h1000 + 16'(i));
                chk("t2_order_data", mon_data[i], 8'hA0 + 8'(i));
            end
        chk("t2_count", write_count, 8);
        chk("t2_ovf_sticky", overflow, 1);

        // Full FIFO with concurrent pop
        mon_addr.delete(); mon_data.delete();
        mem_slot = 0; loader_download = 1;
        step();
        chk("t3_ovf_cleared", overflow, 0);
        chk("t3_count_cleared", write_count, 0);
        for (int i = 0; i < 8; i++) push_byte(16'h2000 + 16'(i), 8'(i));
        chk("t3_wait_full", ioctl_wait, 1);
        mem_slot = 1;
        push_byte(16'h2008, 8'h08);
        chk("t3_no_ovf", overflow, 0);
        chk("t3_we", ram_we, 1);
        chk("t3_head", ram_addr, 16'h2000);
        mem_slot = 0;
        push_byte(16'h2009, 8'h09);
        chk("t3_still_full", overflow, 1);
        mem_slot = 1; loader_download = 0;
        wait_idle(50);
        chk("t3_nwr", mon_addr.size(), 9);
        if (mon_addr.size() == 9) chk("t3_last", mon_addr[8], 16'h2008);
        chk("t3_count", write_count, 9);

        // Entry point: last strobe wins, jump after final drain
        mon_addr.delete(); mon_data.delete();
        mem_slot = 0; loader_download = 1;
        step();
        execute_enable = 1; execute_addr = 16'h5200;
        step();
        execute_enable = 0;
        for (int i = 0; i < 3; i++) push_byte(16'h3000 + 16'(i), 8'h30 + 8'(i));
        execute_enable = 1; execute_addr = 16'h6000;
        step();
        execute_enable = 0;
        chk("t4_no_early_jump", jump_req, 0);
        mem_slot = 1; loader_download = 0;
        n = 0;
        while (!jump_req && n < 50) begin
            step();
            n++;
        end
        chk("t4_jump_req", jump_req, 1);
        chk("t4_writes_first", mon_addr.size(), 3);
        chk("t4_jump_addr", jump_addr, 16'h6000);
        step(); step(); step();
        chk("t4_jump_held", jump_req, 1);
        chk("t4_hold_in_jump", cpu_hold, 1);
        jump_ack = 1;
        step();
        jump_ack = 0;
        chk("t4_jump_dropped", jump_req, 0);
        chk("t4_hold_release", cpu_hold, 1);
        step();
        chk("t4_hold_off", cpu_hold, 0);
        chk("t4_jump_addr_kept", jump_addr, 16'h6000);

        // Reset in the middle of a load
        mon_addr.delete(); mon_data.delete();
        mem_slot = 0; loader_download = 1;
        step();
        for (int i = 0; i < 7; i++) push_byte(16'h5000 + 16'(i), 8'(i));
        mem_slot = 1;
        step();
        chk("t5_we_before", ram_we, 1);
        chk("t5_wait_before", ioctl_wait, 1);
        reset = 1; loader_download = 0;
        #1;
        chk("t5_we_rst", ram_we, 0);
        chk("t5_hold_rst", cpu_hold, 0);
        chk("t5_wait_rst", ioctl_wait, 0);
        mon_addr.delete(); mon_data.delete();
        step(); step();
        reset = 0;
        for (int i = 0; i < 6; i++) step();
        chk("t5_no_writes", mon_addr.size(), 0);

        // Long load across pointer wrap with mem_slot toggling
        loader_download = 1;
        step();
        chk("t6_count_start", write_count, 0);
        chk("t6_hold", cpu_hold, 1);
        pushed = 0;
        for (int c = 0; c < 3000 && pushed < 300; c++) begin
            mem_slot = c[0];
            if (!ioctl_wait) begin
                loader_wr   = 1;
                loader_addr = 16'h4000 + 16'(pushed);
                loader_data = pushed[7:0];
                pushed++;
            end else begin
                loader_wr = 0;
            end
            step();
        end
        loader_wr = 0;
        chk("t6_pushed", pushed, 300);
        mem_slot = 1; loader_download = 0;
        wait_idle(100);
        chk("t6_nwr", mon_addr.size(), 300);
        bad = 0;
        if (mon_addr.size() == 300)
            for (int i = 0; i < 300; i++)
                if (mon_addr[i] !== 16'h4000 + 16'(i) || mon_data[i] !== 8'(i)) bad++;
        chk("t6_order", bad, 0);
        chk("t6_count", write_count, 300);
        chk("t6_no_ovf", overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
